// File: rtl/aes_pkg.sv
// Shared AES constants and helpers, reused by the round, key-expansion and inverse stages.
package aes_pkg;

  localparam int STATE_W = 128;
  localparam logic [7:0] AES_POLY = 8'h1B;

  typedef struct packed {
    logic [STATE_W-1:0] data;
    logic               last;
  } buf_entry_t;

  // Multiply by x in GF(2^8), reducing by the AES polynomial on overflow.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
  endfunction

  // State byte index of row r, column c (column-major).
  function automatic int st_byte(input int r, input int c);
    return r + 4 * c;
  endfunction

endpackage

// File: rtl/mix_column.sv
// Combinational MixColumns on one 32-bit column; byte a is the top row.
module mix_column
  import aes_pkg::*;
(
  input  logic [31:0] col_i,
  output logic [31:0] col_o
);

  logic [7:0] a, b, c, d;

  assign a = col_i[31:24];
  assign b = col_i[23:16];
  assign c = col_i[15:8];
  assign d = col_i[7:0];

  // 3x is written as xtime(x) ^ x.
  assign col_o[31:24] = xtime(a) ^ xtime(b) ^ b ^ c ^ d;
  assign col_o[23:16] = a ^ xtime(b) ^ xtime(c) ^ c ^ d;
  assign col_o[15:8]  = a ^ b ^ xtime(c) ^ xtime(d) ^ d;
  assign col_o[7:0]   = xtime(a) ^ a ^ b ^ c ^ xtime(d);

endmodule

// File: rtl/shift_mix_add.sv
// AES round tail: ShiftRows, MixColumns (bypassed on the final round), AddRoundKey,
// followed by a 2-entry valid/ready output buffer.
module shift_mix_add
  import aes_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] in_data,
  input  logic [STATE_W-1:0] in_key,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_data,
  output logic               out_last
);

  logic [STATE_W-1:0] shifted;
  logic [STATE_W-1:0] mixed;
  logic [STATE_W-1:0] result;

  genvar gc, gr;
  generate
    for (gc = 0; gc < 4; gc++) begin : g_col
      for (gr = 0; gr < 4; gr++) begin : g_row
        assign shifted[STATE_W-1-8*st_byte(gr, gc) -: 8] =
          in_data[STATE_W-1-8*st_byte(gr, (gc + gr) % 4) -: 8];
      end
      mix_column u_mix_column (
        .col_i (shifted[STATE_W-1-32*gc -: 32]),
        .col_o (mixed[STATE_W-1-32*gc -: 32])
      );
    end
  endgenerate

  assign result = (in_last ? shifted : mixed) ^ in_key;

  buf_entry_t buf_q [2];
  buf_entry_t buf_d [2];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;
  logic       push, pop;

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign out_data  = buf_q[rd_ptr_q].data;
  assign out_last  = buf_q[rd_ptr_q].last;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  always_comb begin
    buf_d    = buf_q;
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    count_d  = count_q;
    if (push) begin
      buf_d[wr_ptr_q] = '{data: result, last: in_last};
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_q[0] <= '0;
      buf_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      buf_q    <= buf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: doc/shift_mix_add.md
# shift_mix_add

Registered round-tail stage of the AES encryption datapath. It sits directly downstream of `subs_data` and consumes its 128-bit substituted state. It applies ShiftRows, then MixColumns (skipped on the final round), then AddRoundKey. Results go into a 2-entry output buffer with a valid/ready handshake, so a stalled consumer never drops a round result.

## Interface
Parameters:
- none (state width fixed at 128 bits)

Ports:
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  `in_data`/`in_key`/`in_last` valid this cycle
- `in_ready`  out  1  stage can accept an input this cycle
- `in_data`  in  128  substituted state, i.e. `subs_data` `dout`
- `in_key`  in  128  round key for this round
- `in_last`  in  1  final round: bypass MixColumns
- `out_valid`  out  1  `out_data`/`out_last` hold a result
- `out_ready`  in  1  consumer accepts the result this cycle
- `out_data`  out  128  round output state
- `out_last`  out  1  `in_last` of the result being presented

## Operation
- Byte order: state byte k = `in_data[127-8k -: 8]`, with s[r][c] = byte r+4c (FIPS-197 column-major). Keys use the same order.
- ShiftRows: t[r][c] = s[r][(c+r) mod 4].
- MixColumns, per column, over GF(2^8) with poly 0x11B:
  - m0 = 2a^3b^c^d
  - m1 = a^2b^3c^d
  - m2 = a^b^2c^3d
  - m3 = 3a^b^c^2d
  - xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1B : 0).
- `in_last`=1: m = t (no MixColumns).
- AddRoundKey: result = m ^ `in_key`.
- Transform is purely combinational on the input side. The result is written into the buffer on acceptance.
- Output buffer: 2-entry FIFO of {data[127:0], last}, with read/write pointers and a 2-bit count.
  - Push = `in_valid` & `in_ready`.
  - Pop = `out_valid` & `out_ready`.
- `in_ready` = (count != 2), driven from registered state only. There is no combinational path from `out_ready` to `in_ready`.
- `out_valid` = (count != 0). `out_data`/`out_last` = head entry, stable while `out_valid` & !`out_ready`.
- Simultaneous push and pop:
  - count unchanged, both pointers advance.
  - count=1: the head pops and the new entry becomes the head next cycle.
  - count=0: pop is impossible.
  - count=2: push is blocked.
- Pointers wrap modulo 2.
- `in_valid` with `in_ready`=0: ignored. The upstream must hold its data.

## Timing
- Reset (async assert, sync release) clears count and pointers. `in_ready`=1, `out_valid`=0, `out_data`=0, `out_last`=0. Buffer contents are don't-care but are cleared to 0.
- Latency: an input accepted at edge N appears with `out_valid`=1 after edge N (visible cycle N+1).
- Throughput: 1 state/cycle sustained while `out_ready`=1.
- Reset asserted mid-operation discards all buffered results immediately. No partial outputs after release.
- The critical path is ShiftRows + MixColumns + XOR, with no register inside the transform.

## Structure
- Shared package `aes_pkg`:
  - function `xtime`
  - constant `AES_POLY` = 8'h1B
  - constant `STATE_W` = 128
  - byte-index helper `st_byte(r,c)`
- The same package is reused by the key-expansion and inverse stages.
- Sub-module `mix_column`: 32-bit column in, 32-bit column out, combinational. Instantiated 4× in a generate loop.
- The FIFO is inline; it is too small to justify a sub-module.

## Test plan
- FIPS-197 App. B round 1:
  - Stimulus: `in_data`=d4 27 11 ae e0 bf 98 f1 b8 b4 5d e5 1e 41 52 30, `in_key`=a0 fa fe 17 88 54 2c b1 23 a3 39 39 2a 6c 76 05, `in_last`=0.
  - Required: `out_data`=a4 9c 7f f2 68 9f 35 2b 6b 5b ea 43 02 6a 50 49 one cycle later.
- Final round:
  - Stimulus: `in_data`=e9 09 89 72 cb 31 07 5f 3d 32 7d 94 af 2e 2c b5, `in_key`=d0 14 f9 a8 c9 ee 25 89 e1 3f 0c c8 b6 63 0c a6, `in_last`=1.
  - Required: `out_data`=39 25 84 1d 02 dc 09 fb dc 11 85 97 19 6a 0b 32, `out_last`=1.
- Backpressure:
  - Stimulus: `out_ready`=0, then 3 consecutive valid inputs A, B, C.
  - Required: A and B accepted. `in_ready`=0 from the cycle after B. C is held until `out_ready`=1. Outputs come out in order A, B, C with no loss or duplication.
- Streaming:
  - Stimulus: `out_ready`=1, 16 back-to-back random inputs.
  - Required: 16 outputs on consecutive cycles matching a reference model. `in_ready` stays 1 throughout.
- Reset mid-flight:
  - Stimulus: 2 entries buffered, `reset` pulsed low asynchronously between edges.
  - Required: `out_valid`=0 and `in_ready`=1 immediately. No stale output after release.
- All-zero state and zero key: required `out_data`=0 with `in_last` either 0 or 1.
